sar_search_ctrl: RTL and testbench
==================================

Name: sar_search_ctrl

Overview:
Successive-approximation search controller that works with the team's magnitude comparators. An external comparator answers Eq/Lt/Gt for a presented guess against a hidden target. This block issues the guesses and interprets the answers, converging on the target value in at most WIDTH comparisons. It sits in front of any comparator datapath (comp_N_bit family) whose B operand is the unknown quantity.

Parameters:
WIDTH, 4, bit width of guess/result; legal range 1..16
TMO_CYCLES, 15, cmp_valid wait limit in clocks (used only with SAR_TIMEOUT_EN)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse, begins a search; ignored unless IDLE
guess  output  WIDTH  operand presented to comparator A input
cmp_req  output  1  high while guess is valid and an answer is awaited
cmp_valid  input  1  comparator answer valid this cycle
eq  input  1  guess == target
lt  input  1  guess < target
gt  input  1  guess > target
busy  output  1  search in progress
done  output  1  one-cycle pulse at end of search
found  output  1  result valid; held until next start
err  output  1  protocol/consistency error; held until next start
result  output  WIDTH  converged value; held until next start

Behaviour:
- Reset (async assert, sync-released use): state=IDLE; guess=0, result=0, cmp_req=0, busy=0, done=0, found=0, err=0; bit index k=WIDTH-1.
- States: IDLE, ASK, FIN.
- IDLE + start: clear found/err/result; acc=0; k=WIDTH-1; guess=acc|(1<<k); go ASK next cycle. busy=1 from the cycle after start.
- ASK: cmp_req=1, guess stable. Wait for cmp_valid; answers sampled only when cmp_valid=1.
  - eq: result=guess, found=1 -> FIN.
  - lt: keep bit k (acc=guess). gt: clear bit k (acc unchanged).
  - If k>0 after lt/gt: k=k-1, guess=acc|(1<<(k-1)) presented on the following cycle. cmp_req stays high.
  - If k==0: gt -> result=acc, found=1 -> FIN (target 0 / clear-final case). lt -> err=1, result=guess -> FIN (target above range; impossible for a consistent comparator).
  - Answer not one-hot (none or >1 of eq/lt/gt with cmp_valid): err=1, found=0 -> FIN.
- FIN: done=1 for exactly one cycle, busy=0, cmp_req=0 -> IDLE.
- Latency: 1 cycle start->first cmp_req; each answer advances next cycle; worst case WIDTH answers + 1 cycle to done.
- start while busy: ignored. cmp_valid outside ASK: ignored.
- rst_n low mid-search: immediate abort to reset values; no done pulse.

Optional Feature:
- SAR_TIMEOUT_EN defined: wait counter, cleared on entry to ASK and on each accepted answer. If TMO_CYCLES consecutive ASK cycles pass without cmp_valid, err=1, found=0 -> FIN.
- Not defined: no counter; ASK waits indefinitely.

Decomposition:
- Package sar_pkg: state encoding (IDLE/ASK/FIN), answer codes (ANS_EQ=3'b100, ANS_LT=3'b010, ANS_GT=3'b001), WIDTH range check constant.
- Sub-module sar_ans_check: combinational; takes {eq,lt,gt} and returns a one-hot-valid flag plus decoded answer. Reused by future comparator-driven controllers.

Test Plan:
- WIDTH=4, target 11, ideal comparator, cmp_valid same cycle -> guesses 8,12,10,11; found=1, result=11, done pulse after 4 answers, err=0.
- Target 8 -> single guess 8 answered eq; done on next cycle, result=8, found=1.
- Target 0 -> guesses 8,4,2,1 all gt; result=0, found=1, err=0.
- Target 7, cmp_valid delayed 3 cycles per answer -> guess held stable while waiting; result=7, total cycles = 4 answers × 4 + 1.
- Inject eq=lt=1 on the second answer -> err=1, found=0, done pulse, then a new start clears err.
- With SAR_TIMEOUT_EN, TMO_CYCLES=15, cmp_valid never asserted -> err=1 after 15 ASK cycles. Also assert rst_n low mid-search -> all outputs return to 0 asynchronously with no done pulse.

Source files
------------

// File: rtl/sar_pkg.sv
// Shared types and constants for successive-approximation search controllers.
// State encoding, comparator answer codes and the legal WIDTH range check.
package sar_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ASK  = 2'd1,
        FIN  = 2'd2
    } state_e;

    // Answer codes follow the {eq,lt,gt} bit order presented by the comparator.
    typedef enum logic [2:0] {
        ANS_NONE = 3'b000,
        ANS_GT   = 3'b001,
        ANS_LT   = 3'b010,
        ANS_EQ   = 3'b100
    } ans_e;

    localparam int SAR_WIDTH_MIN = 1;
    localparam int SAR_WIDTH_MAX = 16;

    function automatic bit sar_width_ok(input int w);
        return (w >= SAR_WIDTH_MIN) && (w <= SAR_WIDTH_MAX);
    endfunction

endpackage

// File: rtl/sar_ans_check.sv
// Decodes a comparator {eq,lt,gt} answer and flags whether it is a legal one-hot code.
// Purely combinational so it can sit in front of any comparator-driven controller.
module sar_ans_check
    import sar_pkg::*;
(
    input  logic eq,
    input  logic lt,
    input  logic gt,
    output logic onehot,
    output ans_e ans
);

    always_comb begin
        onehot = 1'b0;
        ans    = ANS_NONE;
        case ({eq, lt, gt})
            3'b100: begin
                onehot = 1'b1;
                ans    = ANS_EQ;
            end
            3'b010: begin
                onehot = 1'b1;
                ans    = ANS_LT;
            end
            3'b001: begin
                onehot = 1'b1;
                ans    = ANS_GT;
            end
            default: begin
                onehot = 1'b0;
                ans    = ANS_NONE;
            end
        endcase
    end

endmodule

// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller driving an external Eq/Lt/Gt comparator.
// Define SAR_TIMEOUT_EN to abort a search when cmp_valid stays low for TMO_CYCLES ASK cycles.
module sar_search_ctrl
    import sar_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int TMO_CYCLES = 15
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] guess,
    output logic             cmp_req,
    input  logic             cmp_valid,
    input  logic             eq,
    input  logic             lt,
    input  logic             gt,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic             err,
    output logic [WIDTH-1:0] result
);

    localparam int               KW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [KW-1:0]    KMAX = KW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    if (!sar_width_ok(WIDTH) || (TMO_CYCLES < 1)) begin : g_param_check
        $error("sar_search_ctrl: WIDTH must be 1..16 and TMO_CYCLES at least 1");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d, acc_new;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] guess_q, guess_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             found_q, found_d;
    logic             err_q, err_d;

    logic             ans_onehot;
    ans_e             ans;

`ifdef SAR_TIMEOUT_EN
    localparam int TW = $clog2(TMO_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;
`endif

    sar_ans_check u_ans_check (
        .eq     (eq),
        .lt     (lt),
        .gt     (gt),
        .onehot (ans_onehot),
        .ans    (ans)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            k_q      <= KMAX;
            guess_q  <= '0;
            result_q <= '0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
`ifdef SAR_TIMEOUT_EN
            tmo_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            k_q      <= k_d;
            guess_q  <= guess_d;
            result_q <= result_d;
            found_q  <= found_d;
            err_q    <= err_d;
`ifdef SAR_TIMEOUT_EN
            tmo_q    <= tmo_d;
`endif
        end
    end

    // acc holds the bits already decided; guess is acc with the bit under test set.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        acc_new  = acc_q;
        k_d      = k_q;
        guess_d  = guess_q;
        result_d = result_q;
        found_d  = found_q;
        err_d    = err_q;
`ifdef SAR_TIMEOUT_EN
        tmo_d    = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    result_d = '0;
                    found_d  = 1'b0;
                    err_d    = 1'b0;
                    acc_d    = '0;
                    k_d      = KMAX;
                    guess_d  = ONE << KMAX;
`ifdef SAR_TIMEOUT_EN
                    tmo_d    = '0;
`endif
                    state_d  = ASK;
                end
            end
            ASK: begin
                if (cmp_valid) begin
`ifdef SAR_TIMEOUT_EN
                    tmo_d = '0;
`endif
                    if (!ans_onehot) begin
                        err_d   = 1'b1;
                        found_d = 1'b0;
                        state_d = FIN;
                    end else if (ans == ANS_EQ) begin
                        result_d = guess_q;
                        found_d  = 1'b1;
                        state_d  = FIN;
                    end else begin
                        acc_new = (ans == ANS_LT) ? guess_q : acc_q;
                        acc_d   = acc_new;
                        if (k_q != '0) begin
                            k_d     = k_q - 1'b1;
                            guess_d = acc_new | (ONE << (k_q - 1'b1));
                        end else if (ans == ANS_GT) begin
                            result_d = acc_new;
                            found_d  = 1'b1;
                            state_d  = FIN;
                        end else begin
                            // Target above every representable value: comparator is inconsistent.
                            err_d    = 1'b1;
                            result_d = guess_q;
                            state_d  = FIN;
                        end
                    end
                end
`ifdef SAR_TIMEOUT_EN
                else if (tmo_q == TW'(TMO_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    found_d = 1'b0;
                    state_d = FIN;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign guess   = guess_q;
    assign result  = result_q;
    assign found   = found_q;
    assign err     = err_q;
    assign busy    = (state_q == ASK);
    assign cmp_req = (state_q == ASK);
    assign done    = (state_q == FIN);

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Self-checking bench for sar_search_ctrl: directed and randomized searches against a
// binary-search reference model; the timeout scenario depends on SAR_TIMEOUT_EN.
module tb_sar_search_ctrl;

    localparam int W   = 4;
    localparam int TMO = 15;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] guess;
    logic         cmp_req;
    logic         cmp_valid;
    logic         eq;
    logic         lt;
    logic         gt;
    logic         busy;
    logic         done;
    logic         found;
    logic         err;
    logic [W-1:0] result;

    int n_cmp;
    int n_bad;

    // Observations captured by applyStimulus for the calling test to judge.
    int   obs_guesses[$];
    int   obs_cycles;
    bit   obs_timed_out;
    bit   obs_unstable;
    logic obs_err_after_start;
    logic obs_busy_after_start;
    logic [W-1:0] obs_result;
    logic obs_found;
    logic obs_err;
    logic obs_done_after;
    logic obs_found_after;

    // Reference model outputs.
    int exp_g[$];
    int exp_result;
    bit exp_found;
    bit exp_err;

    sar_search_ctrl #(.WIDTH(W), .TMO_CYCLES(TMO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .guess     (guess),
        .cmp_req   (cmp_req),
        .cmp_valid (cmp_valid),
        .eq        (eq),
        .lt        (lt),
        .gt        (gt),
        .busy      (busy),
        .done      (done),
        .found     (found),
        .err       (err),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Plain binary search over the bit weights; answer number bad_at is replaced by a corrupt code.
    function automatic void model_search(input int t, input int bad_at);
        int acc;
        int g;
        exp_g.delete();
        acc        = 0;
        exp_found  = 1'b0;
        exp_err    = 1'b0;
        exp_result = 0;
        for (int b = W - 1; b >= 0; b--) begin
            g = acc + (1 << b);
            exp_g.push_back(g);
            if (exp_g.size() - 1 == bad_at) begin
                exp_err = 1'b1;
                return;
            end
            if (g == t) begin
                exp_found  = 1'b1;
                exp_result = g;
                return;
            end
            if (g < t) acc = g;
        end
        exp_found  = 1'b1;
        exp_result = acc;
    endfunction

    // Acts as an ideal comparator answering after 'delay' idle cycles per guess.
    task automatic applyStimulus(input int t, input int delay, input int bad_at, input bit spam_start);
        int wait_cnt;
        int n;
        logic [W-1:0] held;
        obs_guesses.delete();
        obs_timed_out = 1'b0;
        obs_unstable  = 1'b0;
        cmp_valid = 1'b0; eq = 1'b0; lt = 1'b0; gt = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        obs_cycles           = 1;
        obs_err_after_start  = err;
        obs_busy_after_start = busy;
        wait_cnt = 0;
        n        = 0;
        held     = guess;
        while (!done) begin
            if (obs_cycles > 300) begin
                obs_timed_out = 1'b1;
                break;
            end
            cmp_valid = 1'b0; eq = 1'b0; lt = 1'b0; gt = 1'b0; start = 1'b0;
            if (cmp_req) begin
                if (spam_start) start = 1'b1;
                if (wait_cnt == 0) held = guess;
                else if (guess !== held) obs_unstable = 1'b1;
                if (wait_cnt < delay) begin
                    wait_cnt++;
                end else begin
                    obs_guesses.push_back(int'(guess));
                    cmp_valid = 1'b1;
                    if (n == bad_at) begin
                        eq = 1'b1;
                        lt = 1'b1;
                    end else begin
                        eq = (int'(guess) == t);
                        lt = (int'(guess) < t);
                        gt = (int'(guess) > t);
                    end
                    n++;
                    wait_cnt = 0;
                end
            end
            @(posedge clk); #1;
            obs_cycles++;
        end
        cmp_valid = 1'b0; eq = 1'b0; lt = 1'b0; gt = 1'b0; start = 1'b0;
        obs_result = result;
        obs_found  = found;
        obs_err    = err;
        @(posedge clk); #1;
        obs_done_after  = done;
        obs_found_after = found;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0; cmp_valid = 1'b0; eq = 1'b0; lt = 1'b0; gt = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (guess !== '0)   begin n_bad++; $display("[TB] FAIL reset_guess got %0d want 0", guess); end
        n_cmp++; if (result !== '0)  begin n_bad++; $display("[TB] FAIL reset_result got %0d want 0", result); end
        n_cmp++; if (cmp_req !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_cmp_req got %b want 0", cmp_req); end
        n_cmp++; if (busy !== 1'b0)  begin n_bad++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0)  begin n_bad++; $display("[TB] FAIL reset_done got %b want 0", done); end
        n_cmp++; if (found !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_found got %b want 0", found); end
        n_cmp++; if (err !== 1'b0)   begin n_bad++; $display("[TB] FAIL reset_err got %b want 0", err); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_search(input string tag, input int t, input int delay, input int bad_at, input bit spam_start);
        int exp_cycles;
        model_search(t, bad_at);
        applyStimulus(t, delay, bad_at, spam_start);
        exp_cycles = exp_g.size() * (delay + 1) + 1;
        n_cmp++; if (obs_timed_out) begin n_bad++; $display("[TB] FAIL %s_timeout t=%0d got no done within bound", tag, t); end
        n_cmp++; if (obs_guesses.size() != exp_g.size()) begin n_bad++; $display("[TB] FAIL %s_nguess t=%0d got %0d want %0d", tag, t, obs_guesses.size(), exp_g.size()); end
        else begin
            for (int i = 0; i < exp_g.size(); i++) begin
                n_cmp++; if (obs_guesses[i] != exp_g[i]) begin n_bad++; $display("[TB] FAIL %s_guess%0d t=%0d got %0d want %0d", tag, i, t, obs_guesses[i], exp_g[i]); end
            end
        end
        n_cmp++; if (obs_cycles != exp_cycles) begin n_bad++; $display("[TB] FAIL %s_cycles t=%0d got %0d want %0d", tag, t, obs_cycles, exp_cycles); end
        n_cmp++; if (obs_found !== exp_found) begin n_bad++; $display("[TB] FAIL %s_found t=%0d got %b want %b", tag, t, obs_found, exp_found); end
        n_cmp++; if (obs_err !== exp_err) begin n_bad++; $display("[TB] FAIL %s_err t=%0d got %b want %b", tag, t, obs_err, exp_err); end
        if (exp_found) begin
            n_cmp++; if (int'(obs_result) != exp_result) begin n_bad++; $display("[TB] FAIL %s_result t=%0d got %0d want %0d", tag, t, obs_result, exp_result); end
        end
        n_cmp++; if (obs_busy_after_start !== 1'b1) begin n_bad++; $display("[TB] FAIL %s_busy t=%0d got %b want 1", tag, t, obs_busy_after_start); end
        n_cmp++; if (obs_err_after_start !== 1'b0) begin n_bad++; $display("[TB] FAIL %s_errclr t=%0d got %b want 0", tag, t, obs_err_after_start); end
        n_cmp++; if (obs_done_after !== 1'b0) begin n_bad++; $display("[TB] FAIL %s_donewidth t=%0d got %b want 0", tag, t, obs_done_after); end
        n_cmp++; if (obs_found_after !== exp_found) begin n_bad++; $display("[TB] FAIL %s_foundhold t=%0d got %b want %b", tag, t, obs_found_after, exp_found); end
        n_cmp++; if (obs_unstable) begin n_bad++; $display("[TB] FAIL %s_stable t=%0d got guess change while waiting want steady", tag, t); end
    endtask

    task automatic test_directed();
        int tgts[3] = '{11, 8, 0};
        foreach (tgts[i]) test_search("directed", tgts[i], 0, -1, 1'b0);
        test_search("delayed", 7, 3, -1, 1'b0);
        test_search("top", 15, 1, -1, 1'b0);
    endtask

    task automatic test_bad_answer();
        test_search("badans", 13, 0, 1, 1'b0);
        test_search("afterbad", 9, 0, -1, 1'b0);
    endtask

    task automatic test_start_while_busy();
        test_search("startbusy", 6, 1, -1, 1'b1);
    endtask

    task automatic test_ignored_valid();
        test_search("preign", 5, 0, -1, 1'b0);
        cmp_valid = 1'b1; gt = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            n_cmp++; if ({busy, done, cmp_req} !== 3'b000) begin n_bad++; $display("[TB] FAIL ignvalid_ctrl got %b want 000", {busy, done, cmp_req}); end
        end
        n_cmp++; if (result !== W'(5)) begin n_bad++; $display("[TB] FAIL ignvalid_result got %0d want 5", result); end
        n_cmp++; if (found !== 1'b1) begin n_bad++; $display("[TB] FAIL ignvalid_found got %b want 1", found); end
        cmp_valid = 1'b0; gt = 1'b0;
    endtask

    task automatic test_random();
        int t, d, bad;
        bit sp;
        for (int i = 0; i < 20; i++) begin
            t   = $urandom_range(0, (1 << W) - 1);
            d   = $urandom_range(0, 2);
            sp  = 1'($urandom_range(0, 1));
            bad = ($urandom_range(0, 4) == 0) ? $urandom_range(0, W - 1) : -1;
            test_search("random", t, d, bad, sp);
        end
    endtask

    task automatic test_abort();
        bit saw_done;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (guess !== W'(1 << (W - 1))) begin n_bad++; $display("[TB] FAIL abort_preguess got %0d want %0d", guess, 1 << (W - 1)); end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if ({busy, cmp_req, done, found, err, guess, result} !== '0) begin n_bad++; $display("[TB] FAIL abort_async got %b want all zero", {busy, cmp_req, done, found, err, guess, result}); end
        saw_done = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        n_cmp++; if (saw_done) begin n_bad++; $display("[TB] FAIL abort_nodone got done pulse want none"); end
    endtask

    task automatic test_timeout();
        int cyc;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
`ifdef SAR_TIMEOUT_EN
        while (!done && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_cmp++; if (cyc != TMO + 1) begin n_bad++; $display("[TB] FAIL timeout_cycles got %0d want %0d", cyc, TMO + 1); end
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("[TB] FAIL timeout_err got %b want 1", err); end
        n_cmp++; if (found !== 1'b0) begin n_bad++; $display("[TB] FAIL timeout_found got %b want 0", found); end
        @(posedge clk); #1;
`else
        repeat (40) begin
            @(posedge clk); #1;
            cyc++;
            n_cmp++; if ({busy, done} !== 2'b10) begin n_bad++; $display("[TB] FAIL nowait_limit cyc=%0d got %b want 10", cyc, {busy, done}); end
        end
        #1 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
`endif
        test_search("posttmo", 3, 0, -1, 1'b0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_directed();
        test_bad_answer();
        test_start_while_busy();
        test_ignored_valid();
        test_random();
        test_abort();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
